// File: rtl/fb_rect_fill.sv
// Framebuffer rectangle fill engine: writes one pixel value over a clipped
// rectangle in raster order, one write per accepted handshake.
module fb_rect_fill #(
    parameter int COORD_W = 8,
    parameter int PIX_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COORD_W-1:0]     x0,
    input  logic [COORD_W-1:0]     y0,
    input  logic [COORD_W:0]       width,
    input  logic [COORD_W:0]       height,
    input  logic [PIX_W-1:0]       color,
    output logic                   fb_we,
    output logic [2*COORD_W-1:0]   fb_addr,
    output logic [PIX_W-1:0]       fb_wdata,
    input  logic                   fb_ready,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    state_t             state, state_nx;
    logic [COORD_W-1:0] x_cur, y_cur, x_org, x_end, y_end;
    logic [COORD_W:0]   xe_full, ye_full;
    logic [COORD_W-1:0] x_end_c, y_end_c;
    logic               zero_ext, transfer, last_px;
    logic               we_nx, busy_nx, done_nx;

    // Inclusive end coordinates; the carry bit flags a rectangle that runs off screen.
    always_comb begin
        xe_full  = {1'b0, x0} + width  - (COORD_W+1)'(1);
        ye_full  = {1'b0, y0} + height - (COORD_W+1)'(1);
        x_end_c  = xe_full[COORD_W] ? COORD_MAX : xe_full[COORD_W-1:0];
        y_end_c  = ye_full[COORD_W] ? COORD_MAX : ye_full[COORD_W-1:0];
        zero_ext = (width == '0) || (height == '0);
        transfer = (state == S_FILL) && fb_we && fb_ready;
        last_px  = (x_cur == x_end) && (y_cur == y_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = zero_ext ? S_DONE : S_FILL;
            S_FILL: if (transfer && last_px) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they appear
    // in the same cycle as the state they describe.
    always_comb begin
        we_nx   = (state_nx == S_FILL);
        busy_nx = (state_nx == S_FILL);
        done_nx = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            fb_we <= we_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cur    <= '0;
            y_cur    <= '0;
            x_org    <= '0;
            x_end    <= '0;
            y_end    <= '0;
            fb_wdata <= '0;
        end else if (state == S_IDLE && start) begin
            x_cur    <= x0;
            y_cur    <= y0;
            x_org    <= x0;
            x_end    <= x_end_c;
            y_end    <= y_end_c;
            fb_wdata <= color;
        end else if (transfer && !last_px) begin
            if (x_cur != x_end) begin
                x_cur <= x_cur + COORD_W'(1);
            end else begin
                x_cur <= x_org;
                y_cur <= y_cur + COORD_W'(1);
            end
        end
    end

    assign fb_addr = {y_cur, x_cur};

endmodule
